// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID register for a combinational-read instruction memory
// Ports: clk/rst_n clock and async active-low reset; imem_addr/imem_data memory read path;
//   instr_out/pc_out/instr_valid/instr_ready IF/ID handshake toward decode;
//   redirect_valid/redirect_pc branch/jump target; halted set after HALT_INSTR; fetch_count captures since reset.
module instruction_fetch_unit #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [ADDR_W-1:0]  PC_STEP    = ADDR_W'(1),
    parameter logic [DATA_W-1:0]  HALT_INSTR = 32'hFFFF_FFFF,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);
    typedef enum logic {RUN, HALT} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_out_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic              valid_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              slot_free;
    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign slot_free = !instr_valid || instr_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_out   <= instr_nxt;
            pc_out      <= pc_out_nxt;
            instr_valid <= valid_nxt;
            fetch_count <= count_nxt;
        end
    end
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr_out;
        pc_out_nxt = pc_out;
        valid_nxt  = instr_valid;
        count_nxt  = fetch_count;
        if (redirect_valid) begin
            // A redirect flushes the held word even if decode is taking it this cycle.
            pc_nxt    = redirect_pc;
            valid_nxt = 1'b0;
            state_nxt = RUN;
        end else if (state == RUN && slot_free) begin
            instr_nxt  = imem_data;
            pc_out_nxt = pc;
            valid_nxt  = 1'b1;
            count_nxt  = fetch_count + CNT_W'(1);
            // The halt word is delivered but the PC parks on it.
            pc_nxt     = (imem_data == HALT_INSTR) ? pc : pc + PC_STEP;
            state_nxt  = (imem_data == HALT_INSTR) ? HALT : RUN;
        end else if (state == HALT && instr_valid && instr_ready) begin
            valid_nxt = 1'b0;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with a behavioural fetch model and random stimulus
module tb_instruction_fetch_unit;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data, instr_out, pc_out, redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b1, redirect_valid = 1'b0, halted;
    logic [15:0] fetch_count;
    logic [31:0] mem [256];
    int          n_checks = 0, n_fail = 0;
    // Behavioural model: the queue holds the word decode is expected to receive next.
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0, m_halt = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [63:0] exp_q [$];
    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted), .fetch_count(fetch_count)
    );
    assign imem_data = mem[imem_addr[7:0]];
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = '0;
            exp_q.delete();
        end else if (redirect_valid) begin
            if (m_valid && !instr_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            m_pc = redirect_pc; m_valid = 1'b0; m_halt = 1'b0;
        end else if (!m_halt && (!m_valid || instr_ready)) begin
            exp_q.push_back({mem[m_pc[7:0]], m_pc});
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
            if (mem[m_pc[7:0]] == HALT_W) m_halt = 1'b1;
            else m_pc = m_pc + 32'd1;
        end else if (m_halt && m_valid && instr_ready) begin
            m_valid = 1'b0;
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
            chk("instr_valid", 64'(instr_valid), 64'(m_valid));
            chk("halted", 64'(halted), 64'(m_halt));
            chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
                else chk("deliver", {instr_out, pc_out}, exp_q.pop_front());
            end
        end
    end
    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc);
        instr_ready = r; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk); #1;
    endtask
    initial begin
        logic [31:0] stream [5];
        stream = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193, HALT_W};
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 5; i++) mem[i] = stream[i];
        @(negedge clk); #2 rst_n = 1'b1;
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr_out", 64'(instr_out), 64'd0);
        chk("rst_pc_out", 64'(pc_out), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc(1, 0, 0);
            chk("stream_instr", 64'(instr_out), 64'(stream[i]));
            chk("stream_pc", 64'(pc_out), 64'(i));
        end
        chk("stream_halted", 64'(halted), 64'd1);
        chk("stream_count", 64'(fetch_count), 64'd5);
        chk("stream_addr", 64'(imem_addr), 64'd4);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("unhalt", 64'(halted), 64'd0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        chk("bp_instr", 64'(instr_out), 64'h00100093);
        chk("bp_pc_out", 64'(pc_out), 64'd1);
        chk("bp_addr", 64'(imem_addr), 64'd2);
        chk("bp_count", 64'(fetch_count), 64'd7);
        cyc(1, 0, 0);
        chk("bp_release", 64'(pc_out), 64'd2);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        chk("pre_redirect_addr", 64'(imem_addr), 64'd1);
        cyc(1, 1, 3);
        chk("redir_valid", 64'(instr_valid), 64'd0);
        chk("redir_addr", 64'(imem_addr), 64'd3);
        cyc(1, 0, 0);
        chk("redir_instr", 64'(instr_out), 64'h00308193);
        chk("redir_pc_out", 64'(pc_out), 64'd3);
        cyc(0, 1, 2);
        chk("stall_redir_valid", 64'(instr_valid), 64'd0);
        chk("stall_redir_addr", 64'(imem_addr), 64'd2);
        cyc(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", 64'(imem_addr), 64'd0);
        chk("arst_valid", 64'(instr_valid), 64'd0);
        chk("arst_halted", 64'(halted), 64'd0);
        chk("arst_count", 64'(fetch_count), 64'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 1, 32'hFFFF_FFFF);
        cyc(1, 0, 0);
        chk("wrap_addr", 64'(imem_addr), 64'd0);
        chk("wrap_pc_out", 64'(pc_out), 64'hFFFF_FFFF);
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 7) == 0) ? HALT_W : $urandom;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                              : 32'($urandom_range(0, 300));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0), rpc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
